// File: rtl/spi_pkg.sv
// Shared SPI-domain types, opcodes and wipe FSM encoding.
package spi_pkg;

  typedef logic [7:0] spi_byte_t;

  localparam spi_byte_t OP_WIPE_ALL = 8'hFF;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    KEY_A    = 3'd1,
    KEY_B    = 3'd2,
    ASSERT   = 3'd3,
    COOLDOWN = 3'd4
  } wipe_state_t;

endpackage

// File: rtl/wipe_hold_timer.sv
// Loadable saturating down-counter; done_c is high while the count sits at zero.
module wipe_hold_timer #(
  parameter int unsigned MAX_COUNT = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load,
  input  logic [$clog2(MAX_COUNT + 1)-1:0] load_val,
  input  logic                             en,
  output logic                             done_c
);

  localparam int unsigned CW = $clog2(MAX_COUNT + 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - CW'(1);
    end
  end

  assign done_c = (count == '0);

endmodule

// File: rtl/spi_wipe_requester.sv
// Decodes WIPE_ALL from the SPI byte stream and drives a stretched, SCK-gated soft_reset.
// Build option: SPI_WIPE_KEY_CHECK_EN adds the two confirmation bytes, timeout and abort pulse.
module spi_wipe_requester
  import spi_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES     = 16,
  parameter int unsigned COOLDOWN_CYCLES = 64,
  parameter int unsigned TIMEOUT_CYCLES  = 100000,
  parameter spi_byte_t   KEY0            = 8'hA5,
  parameter spi_byte_t   KEY1            = 8'h5A
) (
  input  logic      clk_100m,
  input  logic      rst_100m,
  input  logic      frame_start,
  input  logic      byte_valid,
  input  spi_byte_t byte_data,
  input  logic      sck_rise_pulse,
  input  logic      rst_protect,
  output logic      soft_reset,
  output logic      wipe_busy,
  output logic      wipe_abort
);

  localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned CW = $clog2(COOLDOWN_CYCLES + 1);

  wipe_state_t state;
  wipe_state_t state_next;

  logic first_byte;
  logic sck_seen;
  logic byte_ok_c;
  logic opcode_hit_c;
  logic hold_load_c;
  logic hold_done_c;
  logic cool_load_c;
  logic cool_done_c;

  // A byte arriving with frame_start is the new frame's first byte.
  assign byte_ok_c    = byte_valid && !rst_protect;
  assign opcode_hit_c = byte_ok_c && (frame_start || first_byte) && (byte_data == OP_WIPE_ALL);

`ifdef SPI_WIPE_KEY_CHECK_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] tmo_cnt;
  logic          timeout_hit_c;
  logic          abort_c;
  logic          key_accept_c;
  logic          in_key_c;

  assign in_key_c      = (state == KEY_A) || (state == KEY_B);
  assign timeout_hit_c = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));

  // Inter-byte timeout; restarts on every accepted byte and outside the key states.
  always_ff @(posedge clk_100m) begin
    if (rst_100m) begin
      tmo_cnt <= '0;
    end else if (key_accept_c || !in_key_c) begin
      tmo_cnt <= '0;
    end else if (tmo_cnt != TW'(TIMEOUT_CYCLES)) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk_100m) begin
    if (rst_100m) begin
      wipe_abort <= 1'b0;
    end else begin
      wipe_abort <= abort_c;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^{KEY0, KEY1, 32'(TIMEOUT_CYCLES)};
  assign wipe_abort = 1'b0;
`endif

  always_comb begin
    state_next  = state;
    hold_load_c = 1'b0;
    cool_load_c = 1'b0;
`ifdef SPI_WIPE_KEY_CHECK_EN
    abort_c      = 1'b0;
    key_accept_c = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (opcode_hit_c) begin
`ifdef SPI_WIPE_KEY_CHECK_EN
          state_next   = KEY_A;
          key_accept_c = 1'b1;
`else
          state_next  = ASSERT;
          hold_load_c = 1'b1;
`endif
        end
      end
`ifdef SPI_WIPE_KEY_CHECK_EN
      KEY_A: begin
        if (frame_start) begin
          abort_c = 1'b1;
        end else if (byte_ok_c) begin
          if (byte_data == KEY0) begin
            state_next   = KEY_B;
            key_accept_c = 1'b1;
          end else begin
            abort_c = 1'b1;
          end
        end else if (timeout_hit_c) begin
          abort_c = 1'b1;
        end
        if (abort_c) state_next = IDLE;
      end
      KEY_B: begin
        if (frame_start) begin
          abort_c = 1'b1;
        end else if (byte_ok_c) begin
          if (byte_data == KEY1) begin
            state_next   = ASSERT;
            key_accept_c = 1'b1;
            hold_load_c  = 1'b1;
          end else begin
            abort_c = 1'b1;
          end
        end else if (timeout_hit_c) begin
          abort_c = 1'b1;
        end
        if (abort_c) state_next = IDLE;
      end
`endif
      ASSERT: begin
        if (hold_done_c && (sck_seen || sck_rise_pulse)) begin
          state_next  = COOLDOWN;
          cool_load_c = 1'b1;
        end
      end
      COOLDOWN: begin
        if (cool_done_c) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_100m) begin
    if (rst_100m) begin
      state      <= IDLE;
      first_byte <= 1'b0;
      sck_seen   <= 1'b0;
      soft_reset <= 1'b0;
      wipe_busy  <= 1'b0;
    end else begin
      state      <= state_next;
      first_byte <= byte_valid ? 1'b0 : (frame_start || first_byte);
      sck_seen   <= (state == ASSERT) && (state_next == ASSERT) && (sck_seen || sck_rise_pulse);
      soft_reset <= (state_next == ASSERT);
      wipe_busy  <= (state_next == ASSERT) || (state_next == COOLDOWN);
    end
  end

  // Hold count covers HOLD_CYCLES cycles of ASSERT, cooldown covers COOLDOWN_CYCLES cycles.
  wipe_hold_timer #(.MAX_COUNT(HOLD_CYCLES)) u_hold_timer (
    .clk      (clk_100m),
    .rst      (rst_100m),
    .load     (hold_load_c),
    .load_val (HW'(HOLD_CYCLES - 1)),
    .en       (state == ASSERT),
    .done_c   (hold_done_c)
  );

  wipe_hold_timer #(.MAX_COUNT(COOLDOWN_CYCLES)) u_cool_timer (
    .clk      (clk_100m),
    .rst      (rst_100m),
    .load     (cool_load_c),
    .load_val (CW'(COOLDOWN_CYCLES - 1)),
    .en       (state == COOLDOWN),
    .done_c   (cool_done_c)
  );

endmodule

// File: tb/tb_spi_wipe_requester.sv
// Directed bench for spi_wipe_requester; works with or without SPI_WIPE_KEY_CHECK_EN.
module tb_spi_wipe_requester;

`ifdef SPI_WIPE_KEY_CHECK_EN
  localparam bit KEYS = 1'b1;
`else
  localparam bit KEYS = 1'b0;
`endif
  localparam int unsigned TMO = 200;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_start;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       sck;
  logic       prot;
  logic       soft_reset;
  logic       wipe_busy;
  logic       wipe_abort;

  int tests = 0;
  int fails = 0;
  int saw_wipe;
  int abort_cnt;

  spi_wipe_requester #(
    .HOLD_CYCLES     (16),
    .COOLDOWN_CYCLES (64),
    .TIMEOUT_CYCLES  (TMO),
    .KEY0            (8'hA5),
    .KEY1            (8'h5A)
  ) dut (
    .clk_100m       (clk),
    .rst_100m       (rst),
    .frame_start    (frame_start),
    .byte_valid     (byte_valid),
    .byte_data      (byte_data),
    .sck_rise_pulse (sck),
    .rst_protect    (prot),
    .soft_reset     (soft_reset),
    .wipe_busy      (wipe_busy),
    .wipe_abort     (wipe_abort)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  // Step index s uses b[s], fs[s], bv[s].
  typedef struct packed {
    logic [2:0]      n;
    logic [3:0][7:0] b;
    logic [3:0]      fs;
    logic [3:0]      bv;
    logic            prot;
    logic            ew_key;
    logic            ea_key;
    logic            ew_def;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] n, input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] b3, input logic [3:0] fs,
                              input logic [3:0] bv, input logic p, input logic ew_key,
                              input logic ea_key, input logic ew_def);
    vec_t v;
    v.n = n; v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3;
    v.fs = fs; v.bv = bv; v.prot = p;
    v.ew_key = ew_key; v.ea_key = ea_key; v.ew_def = ew_def;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (soft_reset) saw_wipe = 1;
    if (wipe_abort) abort_cnt++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    saw_wipe = 0;
    abort_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic fs);
    frame_start = fs;
    byte_valid  = 1'b1;
    byte_data   = b;
    tick();
    frame_start = 1'b0;
    byte_valid  = 1'b0;
    byte_data   = 8'h00;
  endtask

  task automatic wipe_seq();
    send_byte(8'hFF, 1'b1);
`ifdef SPI_WIPE_KEY_CHECK_EN
    send_byte(8'hA5, 1'b0);
    send_byte(8'h5A, 1'b0);
`endif
  endtask

  // Starts on the first ASSERT cycle; pulses SCK on cycle sck_at.
  task automatic run_assert(input int sck_at, output int hi, output int cool);
    int c;
    c = 0; hi = 0; cool = 0;
    while (soft_reset && c < 500) begin
      sck = (c == sck_at);
      hi++; c++;
      tick();
    end
    sck = 1'b0;
    while (wipe_busy && c < 500) begin
      cool++; c++;
      tick();
    end
  endtask

  vec_t vecs [9];
  int   sck_at [5] = '{0, 3, 15, 16, 40};
  int   exp_hi [5] = '{16, 16, 16, 17, 41};

  initial begin
    int hi, cool, t, sent;
    vec_t v;
    rst = 1'b1; frame_start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    sck = 1'b0; prot = 1'b0; saw_wipe = 0; abort_cnt = 0;

    vecs[0] = mk(3'd3, 8'hFF, 8'hA5, 8'h5A, 8'h00, 4'b0001, 4'b0111, 1'b0, 1'b1, 1'b0, 1'b1);
    vecs[1] = mk(3'd3, 8'hFF, 8'hA5, 8'h33, 8'h00, 4'b0001, 4'b0111, 1'b0, 1'b0, 1'b1, 1'b1);
    vecs[2] = mk(3'd3, 8'hFF, 8'hA5, 8'h00, 8'h00, 4'b0101, 4'b0111, 1'b0, 1'b0, 1'b1, 1'b1);
    vecs[3] = mk(3'd4, 8'h00, 8'hFF, 8'hA5, 8'h5A, 4'b0001, 4'b1111, 1'b0, 1'b0, 1'b0, 1'b0);
    vecs[4] = mk(3'd3, 8'hFF, 8'hA5, 8'h5A, 8'h00, 4'b0001, 4'b0111, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[5] = mk(3'd3, 8'hFF, 8'h5A, 8'hA5, 8'h00, 4'b0001, 4'b0111, 1'b0, 1'b0, 1'b1, 1'b1);
    vecs[6] = mk(3'd3, 8'hFF, 8'hA5, 8'hFF, 8'h00, 4'b0101, 4'b0111, 1'b0, 1'b0, 1'b1, 1'b1);
    vecs[7] = mk(3'd4, 8'h00, 8'hFF, 8'hA5, 8'h5A, 4'b0001, 4'b1110, 1'b0, 1'b1, 1'b0, 1'b1);
    vecs[8] = mk(3'd3, 8'hFF, 8'hA5, 8'h5A, 8'h00, 4'b0000, 4'b0111, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset state
    tick(); tick();
    check("reset_soft_reset", int'(soft_reset), 0);
    check("reset_wipe_busy", int'(wipe_busy), 0);
    check("reset_wipe_abort", int'(wipe_abort), 0);
    rst = 1'b0;

    // Frame-level vector table
    for (int i = 0; i < 9; i++) begin
      v = vecs[i];
      do_reset();
      prot = v.prot;
      for (int s = 0; s < int'(v.n); s++) begin
        frame_start = v.fs[s];
        byte_valid  = v.bv[s];
        byte_data   = v.b[s];
        tick();
      end
      frame_start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; prot = 1'b0;
      repeat (4) tick();
      check($sformatf("vec%0d_wipe", i), saw_wipe, int'(KEYS ? v.ew_key : v.ew_def));
      check($sformatf("vec%0d_abort", i), abort_cnt, int'(KEYS ? v.ea_key : 1'b0));
    end

    // Hold stretch vs SCK arrival, then cooldown length
    do_reset();
    for (int i = 0; i < 5; i++) begin
      wipe_seq();
      check($sformatf("latency_sck%0d", sck_at[i]), int'(soft_reset), 1);
      run_assert(sck_at[i], hi, cool);
      check($sformatf("hold_sck%0d", sck_at[i]), hi, exp_hi[i]);
      check($sformatf("cooldown_sck%0d", sck_at[i]), cool, 64);
    end

    // Command resent during cooldown is ignored
    do_reset();
    wipe_seq();
    t = 0;
    sck = 1'b1;
    while (soft_reset && t < 100) begin
      tick(); t++;
      sck = 1'b0;
    end
    saw_wipe = 0;
    sent = 0;
    send_byte(8'hFF, 1'b1); sent++;
`ifdef SPI_WIPE_KEY_CHECK_EN
    send_byte(8'hA5, 1'b0); sent++;
    send_byte(8'h5A, 1'b0); sent++;
`endif
    t = 0;
    while (wipe_busy && t < 200) begin
      tick(); t++;
    end
    check("cooldown_ignore_wipe", saw_wipe, 0);
    check("cooldown_ignore_len", sent + t, 64);
    wipe_seq();
    check("after_cooldown_wipe", int'(soft_reset), 1);

    // Reset mid-ASSERT ends the wipe
    do_reset();
    wipe_seq();
    repeat (5) tick();
    rst = 1'b1;
    tick();
    check("midreset_soft_reset", int'(soft_reset), 0);
    check("midreset_wipe_busy", int'(wipe_busy), 0);
    rst = 1'b0;
    tick();
    wipe_seq();
    check("midreset_rewipe", int'(soft_reset), 1);

    // Opcode alone: triggers only without key checking
    do_reset();
    send_byte(8'hFF, 1'b1);
    check("opcode_alone", int'(soft_reset), int'(!KEYS));

`ifdef SPI_WIPE_KEY_CHECK_EN
    // Bad key, then a good frame succeeds
    do_reset();
    send_byte(8'hFF, 1'b1);
    send_byte(8'hA5, 1'b0);
    send_byte(8'h33, 1'b0);
    tick();
    check("badkey_abort", abort_cnt, 1);
    check("badkey_no_wipe", saw_wipe, 0);
    wipe_seq();
    check("badkey_then_good", int'(soft_reset), 1);

    // Timeout after A5
    do_reset();
    send_byte(8'hFF, 1'b1);
    send_byte(8'hA5, 1'b0);
    t = 0;
    while (!wipe_abort && t < 1000) begin
      tick(); t++;
    end
    check("timeout_cycles", t, TMO);
    check("timeout_busy", int'(wipe_busy), 0);
    wipe_seq();
    check("timeout_then_wipe", int'(soft_reset), 1);

    // Key byte one cycle before the timeout is still accepted
    do_reset();
    send_byte(8'hFF, 1'b1);
    repeat (TMO - 2) tick();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h5A, 1'b0);
    check("near_timeout_wipe", int'(soft_reset), 1);
    check("near_timeout_abort", abort_cnt, 0);

    // rst_protect masks the key byte but the timeout keeps running
    do_reset();
    send_byte(8'hFF, 1'b1);
    prot = 1'b1;
    t = 0;
    while (!wipe_abort && t < 1000) begin
      byte_valid = (t == 5);
      byte_data  = 8'hA5;
      tick(); t++;
    end
    byte_valid = 1'b0; prot = 1'b0;
    check("protect_timeout_cycles", t, TMO);
    check("protect_no_wipe", saw_wipe, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
